// File: rtl/lsu_mem_stage.sv
// rtl/lsu_mem_stage.sv - RV32I memory stage: req/ack data bus master with store lane alignment and load extension.
// Optional bus timeout abort is enabled by defining LSU_TIMEOUT_EN.
module lsu_mem_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALU_ResultM,
  input  logic [31:0] WriteDataM,
  input  logic [2:0]  funct3M,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] ReadData,
  output logic        StallM,
  output logic        MisalignM,
  output logic        BusErrM
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_nx;
  logic        op, is_store, sz_byte, sz_half, misaligned, issue, tmo;
  logic [1:0]  off, off_q;
  logic [2:0]  f3_q;
  logic        load_q;
  logic [31:0] wdata_fmt, rdata_fmt;
  logic [3:0]  wstrb_fmt;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // A store wins when both request lines are set; size decode differs between loads and stores.
  assign op       = MemReadM | MemWriteM;
  assign is_store = MemWriteM;
  assign off      = ALU_ResultM[1:0];
  assign sz_byte  = is_store ? (funct3M == 3'b000) : (funct3M[1:0] == 2'b00);
  assign sz_half  = is_store ? (funct3M == 3'b001) : (funct3M[1:0] == 2'b01);

  assign misaligned = (sz_half & off[0]) | (~sz_byte & ~sz_half & (off != 2'b00));
  assign MisalignM  = (state == IDLE) & op & misaligned;
  assign issue      = (state == IDLE) & op & ~misaligned;
  assign StallM     = issue | (state == BUSY);

  always_comb begin
    wdata_fmt = WriteDataM;
    wstrb_fmt = 4'b1111;
    if (!is_store) begin
      wdata_fmt = '0;
      wstrb_fmt = '0;
    end else if (sz_byte) begin
      wdata_fmt = {4{WriteDataM[7:0]}};
      wstrb_fmt = 4'b0001 << off;
    end else if (sz_half) begin
      wdata_fmt = {2{WriteDataM[15:0]}};
      wstrb_fmt = 4'b0011 << {off[1], 1'b0};
    end
  end

  // Lane selection uses the offset captured at issue, not the live M-stage address.
  always_comb begin
    case (off_q)
      2'd1:    lane_b = mem_rdata[15:8];
      2'd2:    lane_b = mem_rdata[23:16];
      2'd3:    lane_b = mem_rdata[31:24];
      default: lane_b = mem_rdata[7:0];
    endcase
    lane_h = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  rdata_fmt = {{24{lane_b[7]}}, lane_b};
      3'b100:  rdata_fmt = {24'b0, lane_b};
      3'b001:  rdata_fmt = {{16{lane_h[15]}}, lane_h};
      3'b101:  rdata_fmt = {16'b0, lane_h};
      default: rdata_fmt = mem_rdata;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt;
  logic          bus_err_q;

  // Fires on the last allowed BUSY cycle; a simultaneous ack takes priority.
  assign tmo     = (state == BUSY) & ~mem_ack & (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign BusErrM = bus_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= tmo;
      if (issue)
        tmo_cnt <= '0;
      else if ((state == BUSY) && !mem_ack)
        tmo_cnt <= tmo_cnt + CW'(1);
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES == 0);
  assign tmo        = 1'b0;
  assign BusErrM    = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (issue) state_nx = BUSY;
      BUSY:    if (mem_ack || tmo) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      ReadData  <= '0;
      off_q     <= '0;
      f3_q      <= '0;
      load_q    <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (MisalignM) begin
            ReadData <= '0;
          end else if (issue) begin
            mem_req   <= 1'b1;
            mem_we    <= is_store;
            mem_addr  <= {ALU_ResultM[31:2], 2'b00};
            mem_wdata <= wdata_fmt;
            mem_wstrb <= wstrb_fmt;
            off_q     <= off;
            f3_q      <= funct3M;
            load_q    <= ~is_store;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (load_q) ReadData <= rdata_fmt;
          end else if (tmo) begin
            mem_req  <= 1'b0;
            ReadData <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Memory-access stage of the 5-stage RV32I pipeline. Sits between the EX/MEM register and the DM/WB register.
- Turns load/store requests from the M stage into a req/ack data-memory bus transaction. Aligns store data and byte strobes, and sign/zero-extends load data.
- Produces the registered ReadData that DM/WB captures, plus a stall to the hazard unit while a transaction is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255, BUSY-state cycles without mem_ack before abort (used only when LSU_TIMEOUT_EN is defined).

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, synchronous, active-high
- ALU_ResultM  in  32  effective byte address
- WriteDataM  in  32  store source (rs2)
- funct3M  in  3  access size/sign (RV32I load/store encoding)
- MemReadM  in  1  load in M stage
- MemWriteM  in  1  store in M stage
- mem_req  out  1  bus request, registered
- mem_we  out  1  1=write, registered
- mem_addr  out  32  word address {addr[31:2],2'b00}, registered
- mem_wdata  out  32  lane-aligned store data, registered
- mem_wstrb  out  4  byte enables, registered
- mem_rdata  in  32  read word, valid with mem_ack
- mem_ack  in  1  one-cycle transaction completion
- ReadData  out  32  formatted load result, registered, to DM/WB
- StallM  out  1  freeze PC/IF/ID/EX/EX-MEM, combinational
- MisalignM  out  1  misaligned access flag, combinational
- BusErrM  out  1  timeout abort flag (0 when feature is off)

Behaviour:
- Reset (sync, rst=1 at edge): state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, ReadData=0, timeout counter=0. Reset mid-transaction abandons it; a later mem_ack is ignored in IDLE.
- op = MemReadM|MemWriteM. If both are set, the access is a store.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0. MisalignM = IDLE & op & misaligned. No request is issued, StallM=0, ReadData<=0.
- States: IDLE, BUSY, DONE.
- IDLE, op aligned: latch mem_addr/mem_we/mem_wdata/mem_wstrb, set mem_req<=1, go to BUSY. StallM=1 this cycle.
- IDLE, no op: ReadData holds, stay in IDLE.
- BUSY: StallM=1; mem_req held at 1 and outputs stable until mem_ack.
- BUSY, mem_ack=1: mem_req<=0, go to DONE. On a load, ReadData<=formatted(mem_rdata); on a store, ReadData holds.
- DONE: StallM=0, so the pipeline advances and DM/WB samples ReadData at the end of this cycle. Go to IDLE unconditionally. The new M-stage instruction is evaluated in IDLE on the following cycle.
- Minimum access: 3 cycles (IDLE issue, BUSY with immediate ack, DONE).
- StallM = (IDLE & op & ~misaligned) | BUSY.
- Store formatting, with o = addr[1:0]:
  - SB (000): wdata = {4{WriteDataM[7:0]}}, wstrb = 4'b0001<<o.
  - SH (001): wdata = {2{WriteDataM[15:0]}}, wstrb = 4'b0011<<(2*addr[1]).
  - SW (010): wdata = WriteDataM, wstrb = 4'b1111.
  - Other funct3 values are treated as SW.
- Load formatting (lane from the latched address, not the live input):
  - LB (000) sign-extends byte o; LBU (100) zero-extends byte o.
  - LH (001) sign-extends halfword addr[1]; LHU (101) zero-extends it.
  - LW (010) passes the word through. Other funct3 values are treated as LW.
- A load's wstrb is 0 and its mem_we is 0.
- mem_ack outside BUSY is ignored.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When the count reaches TIMEOUT_CYCLES: mem_req<=0, ReadData<=0, go to DONE, BusErrM=1 during that DONE cycle only.
  - An ack arriving in the same cycle as the timeout wins: normal completion, no error.
- Not defined: no counter; BUSY waits indefinitely; BusErrM tied to 0.

Test Plan:
- Reset mid-BUSY, then mem_ack=1 one cycle after reset releases → state IDLE, mem_req=0, ReadData=0, StallM=0, ack ignored.
- LB at 0x1003, mem_rdata=0x80FF_1234 with ack on first BUSY cycle → mem_addr=0x1000, ReadData=0xFFFF_FF80 in DONE; StallM pattern 1,1,0.
- LHU at 0x2002, mem_rdata=0xBEEF_0000, ack delayed 4 cycles → ReadData=0x0000_BEEF; StallM high 5 cycles, mem_req stable throughout.
- SB at 0x3001, WriteDataM=0x1234_56AB → mem_we=1, mem_wstrb=4'b0010, mem_wdata=0xABAB_ABAB, ReadData unchanged.
- LW at 0x4002 → MisalignM=1, mem_req stays 0, StallM=0, ReadData=0 next cycle.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=8: LW, no ack → BusErrM=1 for exactly one cycle after 8 BUSY cycles, ReadData=0. Repeat with ack exactly on cycle 8 → BusErrM=0, data captured.
